// File: rtl/gf2m_serial_mul.sv
// gf2m_serial_mul: serial GF(2^DW) multiplier, polynomial basis.
//   res = A*B mod f(x), where f(x) = x^DW + POLY (the x^DW term is implicit).
//   B is consumed MSB-first, one bit per cycle (latency DW). If the macro
//   GF2M_MUL_DIGIT2_EN is defined, two bits are consumed per cycle
//   (latency ceil(DW/2)). Results are identical in both builds.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous reset, active low
//   start   in   operation request, sampled on a rising edge while idle
//   A       in   [DW-1:0] multiplicand, captured on the accepted start edge
//   B       in   [DW-1:0] multiplier, captured on the accepted start edge
//   res     out  [DW-1:0] registered product, updated only on completion
//   finish  out  result valid and unit idle (forced low while start is high)
//
// state | meaning
// IDLE  | waiting for start; res/done hold the last result
// BUSY  | shifting B through the accumulator, one digit per cycle
module gf2m_serial_mul #(
  parameter int            DW   = 257,
  parameter logic [DW-1:0] POLY = 257'h1001
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic [DW-1:0] res,
  output logic          finish
);

`ifdef GF2M_MUL_DIGIT2_EN
  // An odd DW gets one zero bit on top of B so digits stay 2 bits wide.
  localparam int BW   = DW + (DW % 2);
  localparam int ITER = BW / 2;
`else
  localparam int BW   = DW;
  localparam int ITER = DW;
`endif
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] res_q, res_d;
  logic          done_q, done_d;
  logic [DW-1:0] acc_next;

  // Multiply by x modulo f: shift, then fold the overflowing x^DW term back.
  function automatic logic [DW-1:0] mulx(input logic [DW-1:0] v);
    return {v[DW-2:0], 1'b0} ^ (v[DW-1] ? POLY : '0);
  endfunction

`ifdef GF2M_MUL_DIGIT2_EN
  logic [DW-1:0] ax;
  always_comb begin
    ax       = mulx(a_q);
    acc_next = mulx(mulx(acc_q))
             ^ (b_q[BW-1] ? ax  : '0)
             ^ (b_q[BW-2] ? a_q : '0);
  end
  localparam int SHIFT = 2;
`else
  always_comb begin
    acc_next = mulx(acc_q) ^ (b_q[BW-1] ? a_q : '0);
  end
  localparam int SHIFT = 1;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = BW'(B);
          acc_d   = '0;
          done_d  = 1'b0;
          cnt_d   = CW'(ITER - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_next;
        b_d   = b_q << SHIFT;
        if (cnt_q == '0) begin
          res_d   = acc_next;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  // A caller looking at finish in its own start cycle must not see the old result.
  assign finish = done_q & ~start;
  assign res    = res_q;

endmodule
